rob_inp_arb: RTL and testbench
==============================

Name: rob_inp_arb

Overview:
- Sequences access to the reorder buffer's single packet-input port on behalf of p_NUM_SRC independent requesters.
- Round-robin grant; registers the winner's PID/data and issues one ROB write.
- Samples the ROB's registered ack and returns a per-source done or reject pulse.
- Also drives the ROB drain side as a valid/ready bridge to downstream and keeps a head-of-line gap stall counter.

Parameters:
- p_NUM_SRC, 4, number of requesters (2..16).
- p_WORD_LEN, 8, packet data width; must match the ROB.
- p_PID_LEN, 8, packet ID width; must match the ROB.
- p_ROB_SIZE, 8, ROB depth; used for reject classification.
- p_STALL_LEN, 16, width of the stall counter.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_src_valid  in  p_NUM_SRC  per-source request.
- i_src_pid  in  p_NUM_SRC*p_PID_LEN  flattened PIDs; source k at [k*p_PID_LEN +: p_PID_LEN].
- i_src_data  in  p_NUM_SRC*p_WORD_LEN  flattened data, same packing.
- o_src_done  out  p_NUM_SRC  one-hot pulse: packet written to the ROB.
- o_src_reject  out  p_NUM_SRC  one-hot pulse: ROB refused the packet.
- o_rob_inp_pid  out  p_PID_LEN  to ROB input PID.
- o_rob_inp_data  out  p_WORD_LEN  to ROB input data.
- o_rob_inp_en  out  1  to ROB input enable.
- i_rob_inp_ack  in  1  ROB registered ack.
- i_rob_min_pid  in  p_PID_LEN  ROB minimum PID.
- i_rob_max_pid  in  p_PID_LEN  ROB maximum PID.
- i_rob_out_data  in  p_WORD_LEN  ROB head data.
- i_rob_out_valid  in  1  ROB head valid.
- o_rob_out_en  out  1  ROB pop.
- o_dn_data  out  p_WORD_LEN  downstream data.
- o_dn_valid  out  1  downstream valid.
- i_dn_ready  in  1  downstream ready.
- o_busy  out  1  FSM not in IDLE.
- o_hol_stall_cnt  out  p_STALL_LEN  consecutive head-gap cycles.

Behaviour:
- Reset (async assert, sync release): state IDLE, rr pointer 0, grant/PID/data registers 0, all outputs 0, stall counter 0.
- FSM IDLE -> ISSUE -> WAIT -> IDLE; 3 cycles per transaction minimum; o_busy=1 in ISSUE and WAIT.
- IDLE: if any i_src_valid, pick the first set bit searching upward from the rr pointer with wrap. Latch grant index, PID and data; go to ISSUE. Otherwise stay in IDLE.
- ISSUE: o_rob_inp_en=1 for exactly one cycle with the latched PID/data; go to WAIT.
- WAIT: the ROB ack is valid this cycle.
  - Ack=1: o_src_done[g]=1.
  - Ack=0: o_src_reject[g]=1.
  - Pulses are combinational in WAIT, one cycle only.
  - Set rr pointer = (g+1) mod p_NUM_SRC; go to IDLE.
- Source protocol:
  - Hold valid until its done/reject pulse, then deassert by the next edge.
  - PID/data may change after ISSUE, because they were latched in IDLE.
- Valid drop: dropping valid before the pulse does not cancel a latched transaction.
- Ungranted sources: never receive pulses.
- Starvation: none; every requester is granted within p_NUM_SRC transactions.
- Reset mid-transaction: FSM returns to IDLE and no pulse is issued. A write already issued may have landed in the ROB; the source must re-send, and the ROB tolerates duplicates by overwrite.
- Drain side:
  - o_dn_valid=i_rob_out_valid.
  - o_dn_data=i_rob_out_data.
  - o_rob_out_en=i_rob_out_valid&&i_dn_ready.
  - All combinational, zero latency, one pop per cycle max.
- Stall counter:
  - Increment when !i_rob_out_valid && i_rob_max_pid!=i_rob_min_pid.
  - Clear when i_rob_out_valid.
  - Saturate at all ones; never wraps.
- Reject classification, used only by the option below: "ahead" = (pid>i_rob_min_pid) && (pid-i_rob_min_pid >= p_ROB_SIZE), unsigned p_PID_LEN arithmetic, evaluated in WAIT.

Optional Feature:
- Macro: ROB_INP_ARB_RETRY_EN.
- Defined:
  - On ack=0 where the PID is "ahead", no reject pulse is issued and the source stays pending.
  - The rr pointer still advances, so the source is re-arbitrated once others have had a turn.
  - Ack=0 for a PID below the window still pulses reject.
- Undefined: every ack=0 pulses o_src_reject.

Test Plan:
- Single source 0, pid=3, data=0xA5, min_pid=0 -> o_rob_inp_en high 1 cycle (cycle 2), ack=1 -> o_src_done=4'b0001 in cycle 3; o_busy high cycles 2-3.
- Sources 0..3 all valid continuously -> grants in order 0,1,2,3,0, each 3 cycles apart; no double grant.
- Source 2 pid=1 with min_pid=5, ack=0 -> o_src_reject=4'b0100; rr pointer becomes 3.
- Retry: source 1 pid=20, min_pid=0, ROB_SIZE=8, ack=0:
  - Macro off -> reject pulse.
  - Macro on -> no pulse; source 1 re-granted after source 2.
- Drain: out_valid=1, dn_ready toggling 1,0,1 -> o_rob_out_en 1,0,1; head gap for 70000 cycles with max!=min -> counter saturates at 0xFFFF, then clears on out_valid.
- Assert i_reset_n=0 during WAIT -> all outputs 0 immediately, no done pulse, FSM restarts from IDLE after release.

Source files
------------

// File: rtl/rob_inp_arb.sv
// rtl/rob_inp_arb.sv - round-robin arbiter for the ROB packet-input port, drain bridge and head-gap stall counter
// Optional feature macro: ROB_INP_ARB_RETRY_EN (rejects of PIDs ahead of the ROB window stay pending instead of pulsing reject)
module rob_inp_arb #(
    parameter int p_NUM_SRC   = 4,
    parameter int p_WORD_LEN  = 8,
    parameter int p_PID_LEN   = 8,
    parameter int p_ROB_SIZE  = 8,
    parameter int p_STALL_LEN = 16
) (
    input  logic                            i_clk,
    input  logic                            i_reset_n,
    input  logic [p_NUM_SRC-1:0]            i_src_valid,
    input  logic [p_NUM_SRC*p_PID_LEN-1:0]  i_src_pid,
    input  logic [p_NUM_SRC*p_WORD_LEN-1:0] i_src_data,
    output logic [p_NUM_SRC-1:0]            o_src_done,
    output logic [p_NUM_SRC-1:0]            o_src_reject,
    output logic [p_PID_LEN-1:0]            o_rob_inp_pid,
    output logic [p_WORD_LEN-1:0]           o_rob_inp_data,
    output logic                            o_rob_inp_en,
    input  logic                            i_rob_inp_ack,
    input  logic [p_PID_LEN-1:0]            i_rob_min_pid,
    input  logic [p_PID_LEN-1:0]            i_rob_max_pid,
    input  logic [p_WORD_LEN-1:0]           i_rob_out_data,
    input  logic                            i_rob_out_valid,
    output logic                            o_rob_out_en,
    output logic [p_WORD_LEN-1:0]           o_dn_data,
    output logic                            o_dn_valid,
    input  logic                            i_dn_ready,
    output logic                            o_busy,
    output logic [p_STALL_LEN-1:0]          o_hol_stall_cnt
);

    localparam int IDX_W = $clog2(p_NUM_SRC);
    localparam logic [IDX_W:0]     c_NUM_SRC_X  = (IDX_W+1)'(p_NUM_SRC);
    localparam logic [IDX_W-1:0]   c_LAST_IDX   = IDX_W'(p_NUM_SRC - 1);
    localparam logic [p_PID_LEN:0] c_ROB_SIZE_X = (p_PID_LEN+1)'(p_ROB_SIZE);

`ifdef ROB_INP_ARB_RETRY_EN
    localparam bit c_RETRY_EN = 1'b1;
`else
    localparam bit c_RETRY_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       rr_q, rr_d;
    logic [IDX_W-1:0]       gnt_q, gnt_d;
    logic [p_PID_LEN-1:0]   pid_q, pid_d;
    logic [p_WORD_LEN-1:0]  data_q, data_d;
    logic [p_STALL_LEN-1:0] stall_q, stall_d;

    logic                   pick_found;
    logic [IDX_W-1:0]       pick_idx;
    logic [IDX_W:0]         scan_idx;
    logic [p_NUM_SRC-1:0]   gnt_oh;
    logic [p_PID_LEN-1:0]   pid_diff;
    logic                   pid_ahead;
    logic                   hold_retry;

    // Round-robin search: first requester at or above the rr pointer, wrapping around
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int i = 0; i < p_NUM_SRC; i++) begin
            scan_idx = {1'b0, rr_q} + (IDX_W+1)'(i);
            if (scan_idx >= c_NUM_SRC_X) begin
                scan_idx = scan_idx - c_NUM_SRC_X;
            end
            if (!pick_found && i_src_valid[scan_idx[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx[IDX_W-1:0];
            end
        end
    end

    // Reject classification: PID lies beyond the ROB window, so a later retry may succeed
    always_comb begin
        pid_diff   = pid_q - i_rob_min_pid;
        pid_ahead  = (pid_q > i_rob_min_pid) && ({1'b0, pid_diff} >= c_ROB_SIZE_X);
        hold_retry = c_RETRY_EN && pid_ahead;
        gnt_oh     = {{(p_NUM_SRC-1){1'b0}}, 1'b1} << gnt_q;
    end

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            gnt_q   <= '0;
            pid_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            pid_q   <= pid_d;
            data_q  <= data_d;
        end
    end

    // Next-state: latch the winner in IDLE, advance rr pointer when the transaction closes
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        pid_d   = pid_q;
        data_d  = data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    gnt_d   = pick_idx;
                    pid_d   = i_src_pid[pick_idx*p_PID_LEN +: p_PID_LEN];
                    data_d  = i_src_data[pick_idx*p_WORD_LEN +: p_WORD_LEN];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                rr_d    = (gnt_q == c_LAST_IDX) ? '0 : gnt_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: single-cycle ROB write in ISSUE, done/reject pulse in WAIT from the registered ack
    always_comb begin
        o_busy         = (state_q != ST_IDLE);
        o_rob_inp_en   = (state_q == ST_ISSUE);
        o_rob_inp_pid  = pid_q;
        o_rob_inp_data = data_q;
        o_src_done     = '0;
        o_src_reject   = '0;
        if (state_q == ST_WAIT) begin
            if (i_rob_inp_ack) begin
                o_src_done = gnt_oh;
            end else if (!hold_retry) begin
                o_src_reject = gnt_oh;
            end
        end
    end

    // Drain bridge: zero-latency pass-through, pop only when downstream takes the head
    always_comb begin
        o_dn_valid   = i_rob_out_valid;
        o_dn_data    = i_rob_out_data;
        o_rob_out_en = i_rob_out_valid && i_dn_ready;
    end

    // Head-gap stall counter: count while the ROB holds packets but the head is missing
    always_comb begin
        stall_d = stall_q;
        if (i_rob_out_valid) begin
            stall_d = '0;
        end else if ((i_rob_max_pid != i_rob_min_pid) && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // Stall counter register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign o_hol_stall_cnt = stall_q;

endmodule

// File: tb/tb_rob_inp_arb.sv
// tb/tb_rob_inp_arb.sv - scoreboard bench for rob_inp_arb
module tb_rob_inp_arb;

    localparam int N  = 4;
    localparam int WL = 8;
    localparam int PL = 8;
    localparam int SL = 16;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    src_valid;
    logic [N*PL-1:0] src_pid;
    logic [N*WL-1:0] src_data;
    logic [N-1:0]    src_done;
    logic [N-1:0]    src_reject;
    logic [PL-1:0]   rob_inp_pid;
    logic [WL-1:0]   rob_inp_data;
    logic            rob_inp_en;
    logic            rob_ack;
    logic [PL-1:0]   rob_min_pid;
    logic [PL-1:0]   rob_max_pid;
    logic [WL-1:0]   rob_out_data;
    logic            rob_out_valid;
    logic            rob_out_en;
    logic [WL-1:0]   dn_data;
    logic            dn_valid;
    logic            dn_ready;
    logic            busy;
    logic [SL-1:0]   stall_cnt;

    rob_inp_arb #(
        .p_NUM_SRC(N), .p_WORD_LEN(WL), .p_PID_LEN(PL), .p_ROB_SIZE(8), .p_STALL_LEN(SL)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_src_valid(src_valid), .i_src_pid(src_pid), .i_src_data(src_data),
        .o_src_done(src_done), .o_src_reject(src_reject),
        .o_rob_inp_pid(rob_inp_pid), .o_rob_inp_data(rob_inp_data), .o_rob_inp_en(rob_inp_en),
        .i_rob_inp_ack(rob_ack), .i_rob_min_pid(rob_min_pid), .i_rob_max_pid(rob_max_pid),
        .i_rob_out_data(rob_out_data), .i_rob_out_valid(rob_out_valid), .o_rob_out_en(rob_out_en),
        .o_dn_data(dn_data), .o_dn_valid(dn_valid), .i_dn_ready(dn_ready),
        .o_busy(busy), .o_hol_stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int       src;
        logic [7:0] pid;
        logic [7:0] data;
        bit       ack;
        bit       exp_done;
        bit       exp_rej;
        int       gap;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   add_cnt [N];
    int   srv_cnt [N];
    logic [7:0] pid_a [N];
    logic [7:0] data_a [N];
    bit   pend = 0;
    bit   ack_plan = 0;
    int   cyc = 0;
    int   last_en = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // source models: a source requests while it has unserved packets
    always_comb begin
        for (int k = 0; k < N; k++) begin
            src_valid[k]             = (add_cnt[k] != srv_cnt[k]);
            src_pid[k*PL +: PL]      = pid_a[k];
            src_data[k*WL +: WL]     = data_a[k];
        end
    end

    // ROB model: ack is registered from the write enable
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rob_ack <= 1'b0;
        else        rob_ack <= rob_inp_en && ack_plan;
    end

    // scoreboard monitor
    always @(negedge clk) begin
        logic [N-1:0] oh;
        cyc++;
        if (!rst_n) begin
            pend = 0;
            chk("rst_pulses", {src_done, src_reject}, '0);
        end else begin
            if (pend) begin
                oh = 4'b0001 << cur.src;
                chk("done", src_done, cur.exp_done ? oh : '0);
                chk("reject", src_reject, cur.exp_rej ? oh : '0);
                if (cur.exp_done || cur.exp_rej) srv_cnt[cur.src]++;
                pend = 0;
            end else begin
                chk("idle_pulses", {src_done, src_reject}, '0);
            end
            if (rob_inp_en) begin
                if (sb.size() == 0) begin
                    chk("unexp_en", 1, 0);
                end else begin
                    cur = sb.pop_front();
                    chk("inp_pid", rob_inp_pid, cur.pid);
                    chk("inp_data", rob_inp_data, cur.data);
                    if (cur.gap != 0) chk("grant_gap", cyc - last_en, cur.gap);
                    ack_plan = cur.ack;
                    pend = 1;
                end
                last_en = cyc;
            end
        end
    end

    task automatic push(input int s, input bit ack, input bit d, input bit r, input int gap);
        exp_t e;
        e.src = s; e.pid = pid_a[s]; e.data = data_a[s];
        e.ack = ack; e.exp_done = d; e.exp_rej = r; e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while ((sb.size() != 0 || pend) && i < 300) begin
            @(negedge clk);
            i++;
        end
        @(negedge clk);
        if (sb.size() != 0 || pend) chk("drain_timeout", 1, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        rob_min_pid = '0; rob_max_pid = '0;
        rob_out_data = '0; rob_out_valid = 1'b0; dn_ready = 1'b0;
        for (int k = 0; k < N; k++) begin
            add_cnt[k] = 0; srv_cnt[k] = 0; pid_a[k] = '0; data_a[k] = '0;
        end

        // reset state
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_en", rob_inp_en, 0);
        chk("rst_pid", rob_inp_pid, 0);
        chk("rst_data", rob_inp_data, 0);
        chk("rst_stall", stall_cnt, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);

        // single source 0: issue in cycle 2, done in cycle 3
        @(posedge clk); #1;
        pid_a[0] = 8'd3; data_a[0] = 8'hA5;
        push(0, 1, 1, 0, 0);
        add_cnt[0]++;
        @(negedge clk); chk("c1_busy", busy, 0); chk("c1_en", rob_inp_en, 0);
        @(negedge clk); chk("c2_busy", busy, 1); chk("c2_en", rob_inp_en, 1);
        @(negedge clk); chk("c3_busy", busy, 1); chk("c3_done", src_done, 4'b0001); chk("c3_en", rob_inp_en, 0);
        @(negedge clk); chk("c4_busy", busy, 0);
        wait_drain();

        // all sources continuously valid: order 0,1,2,3,0, three cycles apart
        do_reset();
        for (int k = 0; k < N; k++) begin pid_a[k] = 8'(10 + k); data_a[k] = 8'(8'h30 + k); end
        push(0, 1, 1, 0, 0); push(1, 1, 1, 0, 3); push(2, 1, 1, 0, 3);
        push(3, 1, 1, 0, 3); push(0, 1, 1, 0, 3);
        @(posedge clk); #1;
        add_cnt[0] += 2; add_cnt[1]++; add_cnt[2]++; add_cnt[3]++;
        wait_drain();

        // reject below window, then rr pointer resumes at 3
        do_reset();
        rob_min_pid = 8'd5; rob_max_pid = 8'd5;
        pid_a[2] = 8'd1; data_a[2] = 8'h77;
        push(2, 0, 0, 1, 0);
        @(posedge clk); #1 add_cnt[2]++;
        wait_drain();
        pid_a[3] = 8'd6; data_a[3] = 8'h63; pid_a[0] = 8'd7; data_a[0] = 8'h60;
        push(3, 1, 1, 0, 0); push(0, 1, 1, 0, 3);
        @(posedge clk); #1 add_cnt[3]++; add_cnt[0]++;
        wait_drain();

        // ahead-of-window rejection
        do_reset();
        rob_min_pid = 8'd0; rob_max_pid = 8'd0;
        pid_a[1] = 8'd20; data_a[1] = 8'h11; pid_a[2] = 8'd5; data_a[2] = 8'h22;
`ifdef ROB_INP_ARB_RETRY_EN
        push(1, 0, 0, 0, 0); push(2, 1, 1, 0, 3); push(1, 1, 1, 0, 3);
`else
        push(1, 0, 0, 1, 0); push(2, 1, 1, 0, 3);
`endif
        @(posedge clk); #1 add_cnt[1]++; add_cnt[2]++;
        wait_drain();

        // reset during WAIT: no pulse, source re-sends after release
        pid_a[0] = 8'd9; data_a[0] = 8'h5A;
        push(0, 1, 0, 0, 0); push(0, 1, 1, 0, 0);
        @(posedge clk); #1 add_cnt[0]++;
        @(posedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_done", src_done, 0);
        chk("mid_rst_rej", src_reject, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_en", rob_inp_en, 0);
        chk("mid_rst_pid", rob_inp_pid, 0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        wait_drain();
        chk("resend_served", srv_cnt[0], add_cnt[0]);

        // drain bridge
        do_reset();
        rob_out_valid = 1'b1; rob_out_data = 8'hC3;
        dn_ready = 1'b1; #1;
        chk("drain_en1", rob_out_en, 1); chk("dn_valid", dn_valid, 1); chk("dn_data", dn_data, 8'hC3);
        dn_ready = 1'b0; #1;
        chk("drain_en0", rob_out_en, 0);
        dn_ready = 1'b1; #1;
        chk("drain_en2", rob_out_en, 1);

        // stall counter: count, saturate, clear
        @(posedge clk); #1;
        rob_out_valid = 1'b0; rob_max_pid = 8'd5; rob_min_pid = 8'd0;
        repeat (3) @(posedge clk);
        #1 chk("stall_3", stall_cnt, 3);
        repeat (69997) @(posedge clk);
        #1 chk("stall_sat", stall_cnt, 16'hFFFF);
        rob_out_valid = 1'b1;
        @(posedge clk); #1 chk("stall_clr", stall_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
